regfile_writeback: RTL and testbench

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_writeback_pkg.sv | 14 +
 rtl/wb_fifo.sv | 59 +++++
 rtl/regfile_writeback.sv | 96 +++++++++
 tb/tb_regfile_writeback.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_writeback_pkg.sv
// Shared core definitions for the writeback path and the register file.
package regfile_writeback_pkg;

   // Core-wide register index and data widths; the register file uses the same values.
   localparam int CORE_ADDR_WIDTH = 5;
   localparam int CORE_DATA_WIDTH = 64;

   // Which result source wins the single queue slot this cycle.
   typedef enum logic {
      SRC_EX = 1'b0,
      SRC_LS = 1'b1
   } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Result queue: DEPTH entries of {rd, data}. Storage is not reset; only the occupancy state is.
module wb_fifo #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [ADDR_WIDTH-1:0] push_rd,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH-1:0] head_rd,
   output logic [DATA_WIDTH-1:0] head_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [ADDR_WIDTH-1:0] mem_rd   [DEPTH];
   logic [DATA_WIDTH-1:0] mem_data [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic                  do_push;
   logic                  do_pop;

   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign head_rd   = mem_rd[rd_ptr];
   assign head_data = mem_data[rd_ptr];

   // Entry storage write; deliberately unreset since contents are ignored while empty.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_rd[wr_ptr]   <= push_rd;
         mem_data[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two; count holds on push+pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (do_pop && !do_push) count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback stage: arbitrates execute/load results into a queue, drains one entry per
// cycle into the register file, and tracks per-register pending writes for hazard queries.
module regfile_writeback
   import regfile_writeback_pkg::*;
#(
   parameter int ADDR_WIDTH = CORE_ADDR_WIDTH,
   parameter int DATA_WIDTH = CORE_DATA_WIDTH,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  issue_valid,
   input  logic [ADDR_WIDTH-1:0] issue_rd,
   output logic                  issue_ready,
   input  logic                  ex_valid,
   input  logic [ADDR_WIDTH-1:0] ex_rd,
   input  logic [DATA_WIDTH-1:0] ex_data,
   output logic                  ex_ready,
   input  logic                  ls_valid,
   input  logic [ADDR_WIDTH-1:0] ls_rd,
   input  logic [DATA_WIDTH-1:0] ls_data,
   output logic                  ls_ready,
   output logic                  wen,
   output logic [ADDR_WIDTH-1:0] rd,
   output logic [DATA_WIDTH-1:0] dataD,
   input  logic [ADDR_WIDTH-1:0] q_rs1,
   input  logic [ADDR_WIDTH-1:0] q_rs2,
   output logic                  hazard1,
   output logic                  hazard2
);

   localparam int NREG = 1 << ADDR_WIDTH;

   logic                  full;
   logic                  empty;
   logic                  ls_fire;
   logic                  ex_fire;
   logic                  issue_fire;
   wb_src_e               src;
   logic [ADDR_WIDTH-1:0] sel_rd;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  push;
   logic [NREG-1:0]       busy;
   logic [NREG-1:0]       busy_next;

   // Load unit has fixed priority over execute for the single slot.
   assign ls_ready   = !full;
   assign ex_ready   = !full && !ls_valid;
   assign ls_fire    = ls_valid && ls_ready;
   assign ex_fire    = ex_valid && ex_ready;
   assign src        = ls_fire ? SRC_LS : SRC_EX;
   assign sel_rd     = (src == SRC_LS) ? ls_rd : ex_rd;
   assign sel_data   = (src == SRC_LS) ? ls_data : ex_data;
   // x0 results complete the handshake but never occupy the queue.
   assign push       = (ls_fire || ex_fire) && (sel_rd != '0);

   assign issue_ready = !busy[issue_rd] || (issue_rd == '0);
   assign issue_fire  = issue_valid && issue_ready && (issue_rd != '0);
   assign hazard1     = busy[q_rs1];
   assign hazard2     = busy[q_rs2];

   wb_fifo #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_rd  (sel_rd),
      .push_data(sel_data),
      .pop      (wen),
      .full     (full),
      .empty    (empty),
      .head_rd  (rd),
      .head_data(dataD)
   );

   // Head of queue drives the register-file write port and is popped the same cycle.
   assign wen = !empty;

   // Scoreboard update: clear on pop first so a same-edge issue to that register wins.
   always_comb begin
      busy_next = busy;
      if (wen)        busy_next[rd]       = 1'b0;
      if (issue_fire) busy_next[issue_rd] = 1'b1;
      busy_next[0] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy <= '0;
      else     busy <= busy_next;
   end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback plus a standalone wb_fifo full/ordering check.
module tb_regfile_writeback;

   localparam int AW = 5;
   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          issue_valid;
   logic [AW-1:0] issue_rd;
   logic          issue_ready;
   logic          ex_valid;
   logic [AW-1:0] ex_rd;
   logic [DW-1:0] ex_data;
   logic          ex_ready;
   logic          ls_valid;
   logic [AW-1:0] ls_rd;
   logic [DW-1:0] ls_data;
   logic          ls_ready;
   logic          wen;
   logic [AW-1:0] rd;
   logic [DW-1:0] dataD;
   logic [AW-1:0] q_rs1;
   logic [AW-1:0] q_rs2;
   logic          hazard1;
   logic          hazard2;

   logic          f_push;
   logic [AW-1:0] f_rd;
   logic [DW-1:0] f_data;
   logic          f_pop;
   logic          f_full;
   logic          f_empty;
   logic [AW-1:0] f_head_rd;
   logic [DW-1:0] f_head_data;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   regfile_writeback #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
      .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_ready(ex_ready),
      .ls_valid(ls_valid), .ls_rd(ls_rd), .ls_data(ls_data), .ls_ready(ls_ready),
      .wen(wen), .rd(rd), .dataD(dataD),
      .q_rs1(q_rs1), .q_rs2(q_rs2), .hazard1(hazard1), .hazard2(hazard2)
   );

   wb_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(4)) u_fifo_ut (
      .clk(clk), .rst(rst),
      .push(f_push), .push_rd(f_rd), .push_data(f_data), .pop(f_pop),
      .full(f_full), .empty(f_empty), .head_rd(f_head_rd), .head_data(f_head_data)
   );

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      issue_valid = 0; issue_rd = '0;
      ex_valid = 0; ex_rd = '0; ex_data = '0;
      ls_valid = 0; ls_rd = '0; ls_data = '0;
      q_rs1 = '0; q_rs2 = '0;
      f_push = 0; f_rd = '0; f_data = '0; f_pop = 0;
      #12;
      check("rst_wen", wen, 0);
      check("rst_issue_ready", issue_ready, 1);
      check("rst_ex_ready", ex_ready, 1);
      check("rst_ls_ready", ls_ready, 1);
      check("rst_hazard1", hazard1, 0);
      check("rst_hazard2", hazard2, 0);
      check("rst_fifo_empty", f_empty, 1);
      @(posedge clk); #1;
      rst = 1'b0;

      // Single result through the execute port.
      issue_valid = 1; issue_rd = 5; q_rs1 = 5;
      #1;
      check("single_issue_ready", issue_ready, 1);
      check("single_hazard_pre", hazard1, 0);
      tick();
      issue_valid = 0;
      check("single_hazard_issued", hazard1, 1);
      ex_valid = 1; ex_rd = 5; ex_data = 64'h1234;
      #1;
      check("single_ex_ready", ex_ready, 1);
      tick();
      ex_valid = 0;
      check("single_wen", wen, 1);
      check("single_rd", rd, 5);
      check("single_data", dataD, 64'h1234);
      check("single_hazard_n1", hazard1, 1);
      tick();
      check("single_wen_done", wen, 0);
      check("single_hazard_clear", hazard1, 0);

      // Contention: load wins, execute follows next cycle.
      ex_valid = 1; ex_rd = 3; ex_data = 64'h33;
      ls_valid = 1; ls_rd = 4; ls_data = 64'h44;
      #1;
      check("cont_ex_ready_low", ex_ready, 0);
      check("cont_ls_ready", ls_ready, 1);
      tick();
      ls_valid = 0;
      #1;
      check("cont_ex_ready_high", ex_ready, 1);
      check("cont_first_wen", wen, 1);
      check("cont_first_rd", rd, 4);
      check("cont_first_data", dataD, 64'h44);
      tick();
      ex_valid = 0;
      check("cont_second_wen", wen, 1);
      check("cont_second_rd", rd, 3);
      check("cont_second_data", dataD, 64'h33);
      tick();
      check("cont_drained", wen, 0);

      // Back-to-back pushes with steady draining never back-pressure.
      for (int i = 0; i < 5; i++) begin
         ls_valid = 1; ls_rd = AW'(10 + i); ls_data = DW'(64'h100 + i);
         #1;
         check("b2b_ls_ready", ls_ready, 1);
         tick();
         check("b2b_rd", rd, AW'(10 + i));
         check("b2b_data", dataD, DW'(64'h100 + i));
      end
      ls_valid = 0;
      tick();
      check("b2b_drained", wen, 0);

      // x0 result: handshake completes, nothing written.
      ex_valid = 1; ex_rd = 0; ex_data = 64'hFF;
      #1;
      check("x0_ex_ready", ex_ready, 1);
      tick();
      ex_valid = 0;
      check("x0_no_wen", wen, 0);

      // Second issue to a busy register stalls until its write pops.
      issue_valid = 1; issue_rd = 7; q_rs1 = 7;
      tick();
      check("busy7_second_blocked", issue_ready, 0);
      ex_valid = 1; ex_rd = 7; ex_data = 64'h77;
      tick();
      ex_valid = 0;
      check("busy7_wen", wen, 1);
      check("busy7_still_blocked", issue_ready, 0);
      tick();
      check("busy7_released", issue_ready, 1);
      check("busy7_hazard_clear", hazard1, 0);
      issue_valid = 0;

      // Same-edge issue and pop of rd=7: set wins.
      ex_valid = 1; ex_rd = 7; ex_data = 64'h70;
      tick();
      ex_valid = 0;
      check("same_edge_wen", wen, 1);
      check("same_edge_rd", rd, 7);
      issue_valid = 1; issue_rd = 7;
      #1;
      check("same_edge_issue_ready", issue_ready, 1);
      tick();
      issue_valid = 0;
      check("same_edge_wen_done", wen, 0);
      check("same_edge_busy_kept", hazard1, 1);
      check("same_edge_issue_blocked", issue_ready, 0);

      // Reset mid-operation.
      issue_valid = 1; issue_rd = 9; q_rs2 = 9;
      tick();
      issue_valid = 0;
      for (int i = 0; i < 3; i++) begin
         ls_valid = 1; ls_rd = AW'(20 + i); ls_data = DW'(64'h200 + i);
         tick();
      end
      ls_valid = 0;
      check("midrst_wen_before", wen, 1);
      check("midrst_hazard2_before", hazard2, 1);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_wen", wen, 0);
      check("midrst_hazard1", hazard1, 0);
      check("midrst_hazard2", hazard2, 0);
      check("midrst_ls_ready", ls_ready, 1);
      check("midrst_ex_ready", ex_ready, 1);
      @(posedge clk); #3;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("postrst_no_wen", wen, 0);
      end
      issue_rd = 9;
      #1;
      check("postrst_issue_ready", issue_ready, 1);

      // Queue unit: fill, reject a push while full, then drain in order.
      for (int i = 0; i < 4; i++) begin
         f_push = 1; f_rd = AW'(1 + i); f_data = DW'(64'hA0 + i);
         #1;
         check("fifo_not_full", f_full, 0);
         tick();
      end
      check("fifo_full", f_full, 1);
      f_rd = 31; f_data = 64'hDEAD;
      tick();
      f_push = 0;
      check("fifo_still_full", f_full, 1);
      for (int i = 0; i < 4; i++) begin
         f_pop = 1;
         #1;
         check("fifo_head_rd", f_head_rd, AW'(1 + i));
         check("fifo_head_data", f_head_data, DW'(64'hA0 + i));
         tick();
      end
      f_pop = 0;
      check("fifo_empty", f_empty, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
